// File: rtl/sent_pkg.sv
// Shared constants for the SENT transmit CRC generator: mode encodings,
// CRC masks and seeds, per-mode payload/augmentation lengths and FSM states.
package sent_pkg;

  // Frame type encodings carried on mode_i
  localparam logic [2:0] SENT_MODE_FAST6 = 3'b001;
  localparam logic [2:0] SENT_MODE_FAST4 = 3'b010;
  localparam logic [2:0] SENT_MODE_FAST3 = 3'b011;
  localparam logic [2:0] SENT_MODE_SHORT = 3'b100;
  localparam logic [2:0] SENT_MODE_ENH   = 3'b101;

  // CRC4: x^4+x^3+x^2+1, CRC6: x^6+x^4+x^3+1 (top term implicit in the step)
  localparam logic [3:0] CRC4_MASK = 4'b1101;
  localparam logic [3:0] CRC4_SEED = 4'b0101;
  localparam logic [5:0] CRC6_MASK = 6'b011001;
  localparam logic [5:0] CRC6_SEED = 6'b010101;

  // Payload bit counts per mode
  localparam logic [4:0] N_FAST6 = 5'd24;
  localparam logic [4:0] N_FAST4 = 5'd16;
  localparam logic [4:0] N_FAST3 = 5'd12;
  localparam logic [4:0] N_SHORT = 5'd12;
  localparam logic [4:0] N_ENH   = 5'd24;

  // Trailing zero bits fed after the payload
  localparam logic [4:0] A_CRC4 = 5'd4;
  localparam logic [4:0] A_CRC6 = 5'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_AUG   = 2'd2
  } sent_state_e;

  function automatic logic mode_legal(input logic [2:0] m);
    return (m == SENT_MODE_FAST6) || (m == SENT_MODE_FAST4) ||
           (m == SENT_MODE_FAST3) || (m == SENT_MODE_SHORT) ||
           (m == SENT_MODE_ENH);
  endfunction

  function automatic logic [4:0] mode_nbits(input logic [2:0] m);
    logic [4:0] n;
    case (m)
      SENT_MODE_FAST6: n = N_FAST6;
      SENT_MODE_FAST4: n = N_FAST4;
      SENT_MODE_FAST3: n = N_FAST3;
      SENT_MODE_SHORT: n = N_SHORT;
      SENT_MODE_ENH:   n = N_ENH;
      default:         n = 5'd0;
    endcase
    return n;
  endfunction

  function automatic logic mode_crc6(input logic [2:0] m);
    return (m == SENT_MODE_ENH);
  endfunction

endpackage

// File: rtl/sent_crc_step.sv
// One-bit LFSR step of a SENT-style CRC: feedback is the register MSB xor
// the incoming bit; the register shifts left and xors in MASK on feedback.
module sent_crc_step #(
  parameter int          W    = 4,
  parameter logic [W-1:0] MASK = '0
) (
  input  logic [W-1:0] crc_i,
  input  logic         bit_i,
  output logic [W-1:0] crc_o
);

  logic fb;

  // Single combinational step of the serial CRC
  always_comb begin
    fb    = crc_i[W-1] ^ bit_i;
    crc_o = {crc_i[W-2:0], 1'b0} ^ (fb ? MASK : '0);
  end

endmodule

// File: rtl/sent_tx_crc_gen.sv
// SENT transmit CRC generator. Captures a right-justified payload on start,
// feeds it MSB first through a CRC4 or CRC6 LFSR one bit per clock, then
// feeds the zero augmentation bits and presents the result with done_o.
//
// Handshake: start_i is a request pulse that is only looked at while busy_o
// is low; an accepted start raises busy_o from the next cycle until the cycle
// done_o pulses, and a start in the done_o cycle is accepted. There is no
// backpressure on done_o/crc_o; crc_o holds its value until the next result.
module sent_tx_crc_gen
  import sent_pkg::*;
(
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        start_i,
  input  logic [2:0]  mode_i,
  input  logic [23:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [5:0]  crc_o,
  output logic        err_o,
  output sent_state_e state_o
);

  sent_state_e state_q, state_d;
  logic [23:0] shift_q;
  logic [4:0]  cnt_q;
  logic [5:0]  crc_q;
  logic        crc6_q;

  logic        idle;
  logic        start_ok;
  logic        start_bad;
  logic        cnt_zero;
  logic        feed_bit;
  logic [3:0]  step4;
  logic [5:0]  step6;
  logic [5:0]  crc_next;
  logic [4:0]  n_bits;

  assign idle      = (state_q == ST_IDLE);
  assign start_ok  = start_i & idle & mode_legal(mode_i);
  assign start_bad = start_i & idle & ~mode_legal(mode_i);
  assign cnt_zero  = (cnt_q == 5'd0);
  assign n_bits    = mode_nbits(mode_i);
  // Payload bits during SHIFT, zero augmentation bits otherwise
  assign feed_bit  = (state_q == ST_SHIFT) ? shift_q[23] : 1'b0;

  sent_crc_step #(.W(4), .MASK(CRC4_MASK)) u_step4 (
    .crc_i (crc_q[3:0]),
    .bit_i (feed_bit),
    .crc_o (step4)
  );

  sent_crc_step #(.W(6), .MASK(CRC6_MASK)) u_step6 (
    .crc_i (crc_q),
    .bit_i (feed_bit),
    .crc_o (step6)
  );

  assign crc_next = crc6_q ? step6 : {2'b00, step4};

  // State register
  always_ff @(posedge clk_tx) begin
    if (reset_tx) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: payload bits, then augmentation bits, then back to idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_zero) state_d = ST_AUG;
      ST_AUG:   if (cnt_zero) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM-derived outputs
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    state_o = state_q;
  end

  // Datapath: payload capture, LFSR update, bit counter and result pulses
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      shift_q <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      crc6_q  <= 1'b0;
      crc_o   <= '0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= start_bad;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            // Left-justify so the payload MSB sits at bit 23
            shift_q <= data_i << (5'd24 - n_bits);
            cnt_q   <= n_bits - 5'd1;
            crc6_q  <= mode_crc6(mode_i);
            crc_q   <= mode_crc6(mode_i) ? CRC6_SEED : {2'b00, CRC4_SEED};
          end
        end
        ST_SHIFT: begin
          crc_q   <= crc_next;
          shift_q <= shift_q << 1;
          if (cnt_zero) cnt_q <= (crc6_q ? A_CRC6 : A_CRC4) - 5'd1;
          else          cnt_q <= cnt_q - 5'd1;
        end
        ST_AUG: begin
          crc_q <= crc_next;
          if (cnt_zero) begin
            crc_o  <= crc_next;
            done_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_crc_gen.sv
// Self-checking bench for sent_tx_crc_gen: directed zero-payload vectors,
// illegal modes, busy-start rejection, back-to-back starts, mid-run reset
// and random payloads checked against a serial model and a division check.
module tb_sent_tx_crc_gen;
  import sent_pkg::*;

  logic        clk_tx = 1'b0;
  logic        reset_tx;
  logic        start_i;
  logic [2:0]  mode_i;
  logic [23:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  crc_o;
  logic        err_o;
  sent_state_e state_o;

  sent_tx_crc_gen dut (
    .clk_tx   (clk_tx),
    .reset_tx (reset_tx),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .data_i   (data_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .crc_o    (crc_o),
    .err_o    (err_o),
    .state_o  (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_tx = ~clk_tx;

  int unsigned cyc = 0;
  always @(posedge clk_tx) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [5:0]  exp_q[$];
  int unsigned due_q[$];
  logic [2:0]  mode_q[$];
  logic [23:0] data_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int tb_nbits(input logic [2:0] m);
    case (m)
      3'd1: return 24;
      3'd2: return 16;
      3'd3: return 12;
      3'd4: return 12;
      3'd5: return 24;
      default: return 0;
    endcase
  endfunction

  // Bit-serial reference straight from the algorithm description
  function automatic logic [5:0] crc_model(input logic [2:0] m, input logic [23:0] d);
    int n, w;
    logic [5:0] c, msk, lim;
    logic b, fb;
    n   = tb_nbits(m);
    w   = (m == 3'd5) ? 6 : 4;
    c   = (w == 6) ? 6'h15 : 6'h05;
    msk = (w == 6) ? 6'h19 : 6'h0D;
    lim = (w == 6) ? 6'h3F : 6'h0F;
    for (int i = 0; i < n + w; i++) begin
      b  = (i < n) ? d[n-1-i] : 1'b0;
      fb = c[w-1] ^ b;
      c  = (c << 1) & lim;
      if (fb) c = c ^ msk;
    end
    return c;
  endfunction

  // Receiver-style check by polynomial division:
  // crc == (seed * x^(N+A) + payload * x^(A+W)) mod P
  function automatic logic rx_check(input logic [2:0] m, input logic [23:0] d,
                                    input logic [5:0] c);
    int n, w, l;
    logic [63:0] v, p, dm, s;
    n  = tb_nbits(m);
    w  = (m == 3'd5) ? 6 : 4;
    l  = n + w;
    p  = (w == 6) ? 64'h59 : 64'h1D;
    s  = (w == 6) ? 64'h15 : 64'h05;
    dm = {40'd0, d} & ((64'd1 << n) - 64'd1);
    v  = (s << l) ^ (dm << (2 * w));
    for (int i = 63; i >= w; i--)
      if (v[i]) v = v ^ (p << (i - w));
    return (v[5:0] == c);
  endfunction

  // Output monitor: every done_o pops one expected result
  always @(negedge clk_tx) begin
    if (!reset_tx && done_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {31'd0, done_o}, 32'd0);
      end else begin
        logic [5:0]  e;
        int unsigned due;
        logic [2:0]  m;
        logic [23:0] d;
        e   = exp_q.pop_front();
        due = due_q.pop_front();
        m   = mode_q.pop_front();
        d   = data_q.pop_front();
        check("crc", {26'd0, crc_o}, {26'd0, e});
        check("latency", cyc, due);
        check("busy_at_done", {31'd0, busy_o}, 32'd0);
        check("rx_loopback", {31'd0, rx_check(m, d, crc_o)}, 32'd1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled at the following posedge
  task automatic do_start(input logic [2:0] m, input logic [23:0] d,
                          input logic [5:0] e, input bit push);
    start_i = 1'b1;
    mode_i  = m;
    data_i  = d;
    if (push) begin
      exp_q.push_back(e);
      due_q.push_back(cyc + 1 + tb_nbits(m) + ((m == 3'd5) ? 6 : 4));
      mode_q.push_back(m);
      data_q.push_back(d);
    end
    @(posedge clk_tx);
    #1;
    start_i = 1'b0;
    mode_i  = 3'($urandom_range(0, 7));
    data_i  = 24'($urandom);
  endtask

  task automatic flush_q();
    exp_q.delete();
    due_q.delete();
    mode_q.delete();
    data_q.delete();
  endtask

  task automatic wait_drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk_tx);
      if (exp_q.size() == 0 && !busy_o) break;
    end
    if (i == budget) begin
      check("drain_timeout", exp_q.size(), 32'd0);
      flush_q();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0]  prev;
    logic [2:0]  m;
    logic [23:0] d;
    logic [2:0]  ill [3];
    int          k;

    reset_tx = 1'b1;
    start_i  = 1'b0;
    mode_i   = 3'd0;
    data_i   = 24'd0;
    repeat (3) @(negedge clk_tx);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err",  {31'd0, err_o},  32'd0);
    check("rst_crc",  {26'd0, crc_o},  32'd0);
    check("rst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    reset_tx = 1'b0;
    @(negedge clk_tx);

    // Zero payloads with known results
    do_start(3'd1, 24'd0, 6'h05, 1'b1); wait_drain(40);
    do_start(3'd2, 24'd0, 6'h0C, 1'b1); wait_drain(40);
    do_start(3'd3, 24'd0, 6'h09, 1'b1); wait_drain(40);
    do_start(3'd4, 24'd0, 6'h09, 1'b1); wait_drain(40);
    do_start(3'd5, 24'd0, 6'h26, 1'b1); wait_drain(40);

    // Illegal modes: error pulse only
    ill[0] = 3'd6; ill[1] = 3'd0; ill[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      prev = crc_o;
      do_start(ill[i], 24'($urandom), 6'd0, 1'b0);
      @(negedge clk_tx);
      check("ill_err_pulse", {31'd0, err_o}, 32'd1);
      check("ill_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk_tx);
      check("ill_err_clear", {31'd0, err_o}, 32'd0);
      check("ill_crc_held", {26'd0, crc_o}, {26'd0, prev});
    end

    // Start while busy is ignored
    d = 24'hA5C3F0;
    do_start(3'd1, d, crc_model(3'd1, d), 1'b1);
    repeat (4) @(negedge clk_tx);
    do_start(3'd5, 24'h123456, 6'd0, 1'b0);
    @(negedge clk_tx);
    check("busy_start_no_err", {31'd0, err_o}, 32'd0);
    check("busy_still", {31'd0, busy_o}, 32'd1);
    wait_drain(40);

    // Back-to-back: new start in the done_o cycle
    d = 24'($urandom);
    do_start(3'd2, d, crc_model(3'd2, d), 1'b1);
    for (k = 0; k < 40; k++) begin
      @(negedge clk_tx);
      if (done_o) break;
    end
    check("b2b_first_done_seen", {31'd0, done_o}, 32'd1);
    d = 24'($urandom);
    do_start(3'd3, d, crc_model(3'd3, d), 1'b1);
    @(negedge clk_tx);
    check("b2b_busy", {31'd0, busy_o}, 32'd1);
    wait_drain(40);

    // Reset in the middle of an enhanced-serial computation
    d = 24'($urandom);
    do_start(3'd5, d, crc_model(3'd5, d), 1'b1);
    repeat (9) @(negedge clk_tx);
    reset_tx = 1'b1;
    flush_q();
    @(negedge clk_tx);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    check("midrst_crc",  {26'd0, crc_o},  32'd0);
    check("midrst_state", {30'd0, state_o}, {30'd0, ST_IDLE});
    reset_tx = 1'b0;
    repeat (35) @(negedge clk_tx);
    check("midrst_idle_after", {31'd0, busy_o}, 32'd0);
    d = 24'($urandom);
    do_start(3'd5, d, crc_model(3'd5, d), 1'b1);
    wait_drain(40);

    // Random payloads across all legal modes; upper bits carry junk
    for (int i = 0; i < 200; i++) begin
      m = 3'($urandom_range(1, 5));
      d = 24'($urandom);
      do_start(m, d, crc_model(m, d), 1'b1);
      wait_drain(40);
      repeat ($urandom_range(0, 2)) @(negedge clk_tx);
    end

    repeat (3) @(negedge clk_tx);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
